// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants fetch/load/store requests one at a time onto a single memory port
//   clk, reset (async, active-low)
//   fetch_req_* / fetch_resp_* : instruction fetch request and response with exception code
//   rd_req_*    / rd_resp_*    : load request and response with exception code
//   wr_req_*    / wr_resp_*    : store request and completion with exception code
//   mem_req_* / mem_resp_*     : single outstanding transaction to the memory array
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [31:0] fetch_req_addr,
  output logic        fetch_resp_valid,
  output logic [31:0] fetch_resp_inst,
  output logic        fetch_resp_exc_valid,
  output logic [3:0]  fetch_resp_exc_code,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [31:0] rd_req_addr,
  output logic        rd_resp_valid,
  output logic [31:0] rd_resp_data,
  output logic        rd_resp_exc_valid,
  output logic [3:0]  rd_resp_exc_code,
  input  logic        wr_req_valid,
  output logic        wr_req_ready,
  input  logic [31:0] wr_req_addr,
  input  logic [31:0] wr_req_data,
  output logic        wr_resp_valid,
  output logic        wr_resp_exc_valid,
  output logic [3:0]  wr_resp_exc_code,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam logic [1:0] CL_F = 2'd0, CL_R = 2'd1, CL_W = 2'd2;
  logic [1:0]    state_q, state_d, client_q, client_d, gnt_id;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, res_q, res_d, gnt_addr;
  logic          exc_q, exc_d, idle, force_f, grant;
  logic [3:0]    code_q, code_d, base;
  always_comb begin
    // readies are held low while reset is asserted even though the FSM sits in IDLE
    idle            = (state_q == IDLE) && reset;
    force_f         = fetch_req_valid && (starve_q == SW'(STARVE_LIMIT));
    wr_req_ready    = idle && wr_req_valid && !force_f;
    rd_req_ready    = idle && rd_req_valid && !wr_req_valid && !force_f;
    fetch_req_ready = idle && fetch_req_valid && (force_f || !(wr_req_valid || rd_req_valid));
    grant           = wr_req_ready || rd_req_ready || fetch_req_ready;
    gnt_id          = wr_req_ready ? CL_W : rd_req_ready ? CL_R : CL_F;
    gnt_addr        = wr_req_ready ? wr_req_addr : rd_req_ready ? rd_req_addr : fetch_req_addr;
    // misalignment code per client; access fault is this value plus one
    base = ((state_q == IDLE) ? gnt_id : client_q) == CL_W ? 4'd6 :
           ((state_q == IDLE) ? gnt_id : client_q) == CL_R ? 4'd4 : 4'd0;
  end
  always_comb begin
    state_d  = state_q;
    client_d = client_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    res_d    = res_q;
    exc_d    = exc_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        starve_d = (fetch_req_ready || !fetch_req_valid) ? '0 :
                   (grant && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
        if (grant) begin
          client_d = gnt_id;
          addr_d   = gnt_addr;
          wdata_d  = wr_req_data;
          state_d  = (|gnt_addr[1:0]) ? RESP : ISSUE;
          exc_d    = |gnt_addr[1:0];
          code_d   = (|gnt_addr[1:0]) ? base : 4'd0;
          res_d    = '0;
        end
      end
      ISSUE: begin
        state_d = mem_req_ready ? WAIT : ISSUE;
        tmo_d   = mem_req_ready ? '0 : tmo_q;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = RESP;
          exc_d   = mem_resp_err;
          code_d  = mem_resp_err ? base + 4'd1 : 4'd0;
          res_d   = mem_resp_err ? '0 : mem_resp_rdata;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = RESP;
          exc_d   = 1'b1;
          code_d  = base + 4'd1;
          res_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      client_q <= CL_F;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      client_q <= client_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      code_q   <= code_d;
    end
  end
  assign fetch_resp_valid     = (state_q == RESP) && (client_q == CL_F);
  assign rd_resp_valid        = (state_q == RESP) && (client_q == CL_R);
  assign wr_resp_valid        = (state_q == RESP) && (client_q == CL_W);
  assign fetch_resp_exc_valid = fetch_resp_valid && exc_q;
  assign rd_resp_exc_valid    = rd_resp_valid && exc_q;
  assign wr_resp_exc_valid    = wr_resp_valid && exc_q;
  assign fetch_resp_exc_code  = code_q;
  assign rd_resp_exc_code     = code_q;
  assign wr_resp_exc_code     = code_q;
  assign fetch_resp_inst      = res_q;
  assign rd_resp_data         = res_q;
  assign mem_req_valid        = state_q == ISSUE;
  assign mem_req_we           = mem_req_valid && (client_q == CL_W);
  assign mem_req_addr         = addr_q;
  assign mem_req_wdata        = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam logic [1:0] C_F = 2'd0, C_R = 2'd1, C_W = 2'd2;
  logic clk, reset;
  logic fetch_req_valid, fetch_req_ready, fetch_resp_valid, fetch_resp_exc_valid;
  logic [31:0] fetch_req_addr, fetch_resp_inst;
  logic [3:0] fetch_resp_exc_code;
  logic rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_exc_valid;
  logic [31:0] rd_req_addr, rd_resp_data;
  logic [3:0] rd_resp_exc_code;
  logic wr_req_valid, wr_req_ready, wr_resp_valid, wr_resp_exc_valid;
  logic [31:0] wr_req_addr, wr_req_data;
  logic [3:0] wr_resp_exc_code;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, mem_resp_err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic mem_silent, stray_pulse, cfg_err, mem_pend;
  logic [31:0] cfg_rdata;
  logic [150:0] allout;
  int n_chk, n_fail;

  typedef struct {
    logic [1:0]  cl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        sil;
    int          lat;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] data;
    logic        mem;
  } vec_t;
  vec_t tv[10];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_req_addr(fetch_req_addr),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_inst(fetch_resp_inst),
    .fetch_resp_exc_valid(fetch_resp_exc_valid), .fetch_resp_exc_code(fetch_resp_exc_code),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rd_resp_exc_valid(rd_resp_exc_valid), .rd_resp_exc_code(rd_resp_exc_code),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_resp_valid(wr_resp_valid),
    .wr_resp_exc_valid(wr_resp_exc_valid), .wr_resp_exc_code(wr_resp_exc_code),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  assign allout = {fetch_req_ready, rd_req_ready, wr_req_ready,
                   fetch_resp_valid, fetch_resp_inst, fetch_resp_exc_valid, fetch_resp_exc_code,
                   rd_resp_valid, rd_resp_data, rd_resp_exc_valid, rd_resp_exc_code,
                   wr_resp_valid, wr_resp_exc_valid, wr_resp_exc_code,
                   mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // memory model: always ready, answers one cycle after accept unless silenced
  initial begin
    mem_req_ready = 1;
    mem_resp_valid = 0;
    mem_resp_rdata = 0;
    mem_resp_err = 0;
    mem_pend = 0;
    forever begin
      @(negedge clk);
      #2;
      mem_resp_valid = 0;
      if (stray_pulse || (mem_pend && !mem_silent)) begin
        mem_resp_valid = 1;
        mem_resp_rdata = stray_pulse ? 32'hBAD0BAD0 : cfg_rdata;
        mem_resp_err = stray_pulse ? 1'b0 : cfg_err;
      end
      mem_pend = mem_req_valid && mem_req_ready;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] cl, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input logic sil, input int lat,
                              input logic exc, input logic [3:0] code, input logic [31:0] data, input logic mem);
    vec_t v;
    v.cl = cl; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err; v.sil = sil;
    v.lat = lat; v.exc = exc; v.code = code; v.data = data; v.mem = mem;
    return v;
  endfunction

  task automatic drive_req(input logic [1:0] cl, input logic [31:0] a, input logic [31:0] d);
    fetch_req_valid = (cl == C_F);
    rd_req_valid = (cl == C_R);
    wr_req_valid = (cl == C_W);
    fetch_req_addr = a;
    rd_req_addr = a;
    wr_req_addr = a;
    wr_req_data = d;
  endtask

  task automatic drop_reqs();
    fetch_req_valid = 0;
    rd_req_valid = 0;
    wr_req_valid = 0;
  endtask

  task automatic run(input vec_t v, input string nm);
    logic [2:0] vs;
    logic gexc, seen, mwe;
    logic [3:0] gcode;
    logic [31:0] gdata, maddr, mwd;
    int lat;
    vs = 0; gexc = 0; seen = 0; mwe = 0; gcode = 0; gdata = 0; maddr = 0; mwd = 0; lat = 0;
    cfg_rdata = v.rdata;
    cfg_err = v.err;
    mem_silent = v.sil;
    @(negedge clk);
    drive_req(v.cl, v.addr, v.wdata);
    #1;
    chk({nm, "_ready"}, v.cl == C_W ? wr_req_ready : v.cl == C_R ? rd_req_ready : fetch_req_ready, 1);
    @(negedge clk);
    drop_reqs();
    for (int k = 1; k <= 100; k++) begin
      if (mem_req_valid && !seen) begin
        seen = 1; mwe = mem_req_we; maddr = mem_req_addr; mwd = mem_req_wdata;
      end
      if (fetch_resp_valid || rd_resp_valid || wr_resp_valid) begin
        lat = k;
        vs = {wr_resp_valid, rd_resp_valid, fetch_resp_valid};
        gexc = v.cl == C_W ? wr_resp_exc_valid : v.cl == C_R ? rd_resp_exc_valid : fetch_resp_exc_valid;
        gcode = v.cl == C_W ? wr_resp_exc_code : v.cl == C_R ? rd_resp_exc_code : fetch_resp_exc_code;
        gdata = v.cl == C_R ? rd_resp_data : fetch_resp_inst;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    mem_silent = 0;
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_resp_onehot"}, vs, 3'b001 << v.cl);
    chk({nm, "_exc_valid"}, gexc, v.exc);
    if (v.exc) chk({nm, "_exc_code"}, gcode, v.code);
    if (v.cl != C_W && (v.cl == C_R || !v.exc)) chk({nm, "_data"}, gdata, v.data);
    chk({nm, "_mem_access"}, seen, v.mem);
    if (v.mem) begin
      chk({nm, "_mem_we"}, mwe, v.cl == C_W);
      chk({nm, "_mem_addr"}, maddr, v.addr);
      if (v.cl == C_W) chk({nm, "_mem_wdata"}, mwd, v.wdata);
    end
  endtask

  initial begin
    logic [1:0] order[6];
    logic [1:0] exp_order[6];
    logic mwe, seenm;
    int ng, gk, cnt;
    n_chk = 0;
    n_fail = 0;
    reset = 0;
    mem_silent = 0;
    stray_pulse = 0;
    cfg_err = 0;
    cfg_rdata = 0;
    drop_reqs();
    fetch_req_addr = 0; rd_req_addr = 0; wr_req_addr = 0; wr_req_data = 0;
    tv[0] = mk(C_R, 32'h100, 0, 32'hDEADBEEF, 0, 0, 3, 0, 0, 32'hDEADBEEF, 1);
    tv[1] = mk(C_W, 32'h102, 32'h11223344, 0, 0, 0, 1, 1, 4'd6, 0, 0);
    tv[2] = mk(C_F, 32'h201, 0, 0, 0, 0, 1, 1, 4'd0, 0, 0);
    tv[3] = mk(C_R, 32'h003, 0, 0, 0, 0, 1, 1, 4'd4, 0, 0);
    tv[4] = mk(C_F, 32'h200, 0, 32'h00000013, 0, 0, 3, 0, 0, 32'h00000013, 1);
    tv[5] = mk(C_W, 32'h300, 32'hCAFEF00D, 32'h5555, 0, 0, 3, 0, 0, 0, 1);
    tv[6] = mk(C_R, 32'h104, 0, 32'hFFFF0000, 1, 0, 3, 1, 4'd5, 0, 1);
    tv[7] = mk(C_W, 32'h108, 32'h0BADF00D, 0, 1, 0, 3, 1, 4'd7, 0, 1);
    tv[8] = mk(C_F, 32'h204, 0, 32'h12345678, 1, 0, 3, 1, 4'd1, 0, 1);
    tv[9] = mk(C_F, 32'h200, 0, 0, 0, 1, 66, 1, 4'd1, 0, 1);
    exp_order = '{C_R, C_R, C_R, C_R, C_F, C_R};
    order = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs_zero", $countones(allout), 0);
    @(negedge clk);
    reset = 1;
    #1 chk("post_reset_outputs_zero", $countones(allout), 0);
    for (int i = 0; i < 10; i++) run(tv[i], $sformatf("vec%0d", i));
    // late memory response after the timeout must be dropped
    @(negedge clk);
    stray_pulse = 1;
    @(negedge clk);
    stray_pulse = 0;
    cnt = 0;
    repeat (4) begin
      cnt += fetch_resp_valid + rd_resp_valid + wr_resp_valid + mem_req_valid;
      @(negedge clk);
    end
    chk("late_resp_dropped", cnt, 0);
    // write beats read in the same cycle; read follows in the next IDLE
    cfg_rdata = 32'h77;
    @(negedge clk);
    wr_req_valid = 1; wr_req_addr = 32'h600; wr_req_data = 32'hA5A5A5A5;
    rd_req_valid = 1; rd_req_addr = 32'h604;
    #1;
    chk("prio_wr_ready", wr_req_ready, 1);
    chk("prio_rd_blocked", rd_req_ready, 0);
    @(negedge clk);
    wr_req_valid = 0;
    seenm = 0; mwe = 0; gk = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      if (mem_req_valid && !seenm) begin seenm = 1; mwe = mem_req_we; end
      if (rd_req_ready) begin gk = k; break; end
      @(negedge clk);
    end
    chk("prio_wr_mem_we", mwe, 1);
    chk("prio_rd_next_idle", gk, 4);
    @(negedge clk);
    rd_req_valid = 0;
    #1;
    chk("prio_rd_issue", mem_req_valid, 1);
    chk("prio_rd_we", mem_req_we, 0);
    chk("prio_rd_addr", mem_req_addr, 32'h604);
    repeat (4) @(negedge clk);
    // starvation guard with rd and fetch held valid
    rd_req_valid = 1; rd_req_addr = 32'h400;
    fetch_req_valid = 1; fetch_req_addr = 32'h500;
    ng = 0;
    for (int k = 0; k < 200 && ng < 6; k++) begin
      #1;
      if (rd_req_ready) begin order[ng] = C_R; ng++; end
      else if (fetch_req_ready) begin order[ng] = C_F; ng++; end
      @(negedge clk);
    end
    drop_reqs();
    for (int i = 0; i < 6; i++) chk($sformatf("starve_grant%0d", i), order[i], exp_order[i]);
    repeat (5) @(negedge clk);
    // reset in WAIT, then a stray memory response
    mem_silent = 1;
    rd_req_valid = 1; rd_req_addr = 32'h700;
    @(negedge clk);
    rd_req_valid = 0;
    #1 chk("rst_seq_issue", mem_req_valid, 1);
    repeat (2) @(negedge clk);
    reset = 0;
    #1 chk("mid_reset_outputs_zero", $countones(allout), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    mem_silent = 0;
    stray_pulse = 1;
    @(negedge clk);
    stray_pulse = 0;
    cnt = 0;
    repeat (6) begin
      #1 cnt += $countones(allout);
      @(negedge clk);
    end
    chk("after_reset_quiet", cnt, 0);
    run(tv[0], "post_reset_load");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
